// File: rtl/fpu_pkg.sv
// Shared types and bfloat16 constants for the FPU round/pack datapath.
package fpu_pkg;

  // bfloat16 field widths; the exponent bias is 2**(EXP_W-1)-1.
  localparam int BF16_EXP_W  = 8;
  localparam int BF16_FRAC_W = 7;

  // Canonical quiet NaN: positive sign, all-ones exponent, fraction MSB set.
  localparam logic [15:0] BF16_CANON_NAN = 16'h7FC0;

  // Exception flags attached to each packed result.
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational mantissa rounder for the post-multiply stage.
// Build option: FP_ROUND_RNE_EN defined selects round-to-nearest-even;
// left undefined, the mantissa is truncated (never incremented).
// Inexact is reported either way from the dropped guard/sticky bits.
module fp_rne_round #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
) (
  input  logic [FRAC_WIDTH:0]          man,
  input  logic                         grd,
  input  logic                         stk,
  input  logic signed [EXP_WIDTH+1:0]  exp_in,
  output logic [FRAC_WIDTH:0]          man_r,
  output logic signed [EXP_WIDTH+2:0]  exp_r,
  output logic                         inexact
);

  localparam int XW = EXP_WIDTH + 3;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

  logic                    round_up;
  logic [FRAC_WIDTH+1:0]   man_sum;
  logic signed [XW-1:0]    exp_ext;

`ifdef FP_ROUND_RNE_EN
  // Round up when above half, or exactly half with an odd LSB (ties to even).
  assign round_up = grd & (stk | man[0]);
`else
  assign round_up = 1'b0;
`endif

  // One extra exponent bit so that an increment can never wrap the sign.
  assign exp_ext = {exp_in[EXP_WIDTH+1], exp_in};
  assign man_sum = {1'b0, man} + {{(FRAC_WIDTH+1){1'b0}}, round_up};
  assign inexact = grd | stk;

  // A carry out of 1.11..1 renormalises to 1.00..0 with the exponent bumped.
  always_comb begin
    man_r = man_sum[FRAC_WIDTH:0];
    exp_r = exp_ext;
    if (man_sum[FRAC_WIDTH+1]) begin
      man_r = {1'b1, {FRAC_WIDTH{1'b0}}};
      exp_r = exp_ext + EXP_ONE;
    end
  end

endmodule

// File: rtl/fp_round_pack.sv
// Post-multiply round/pack stage for the bfloat16 FPU datapath.
// S1 registers the rounded product, S2 classifies and packs {sign,exp,frac}
// and holds it on the output with exception flags. A sticky flag register
// accumulates flags of every delivered result until flag_clr.
// Build option: FP_ROUND_RNE_EN (round-to-nearest-even; truncation otherwise).
//
// Handshake: a beat moves when valid and ready are both high at a clock edge.
// in_ready is a pure function of pipeline occupancy and out_ready (never of
// in_valid); once out_valid rises, out_data/out_flags hold until a cycle in
// which out_ready is high.
module fp_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH  = BF16_EXP_W,
  parameter int FRAC_WIDTH = BF16_FRAC_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sign,
  input  logic [EXP_WIDTH+1:0]            in_exp,
  input  logic [FRAC_WIDTH:0]             in_man,
  input  logic                            in_grd,
  input  logic                            in_stk,
  input  logic                            in_nan,
  input  logic                            in_inf,
  input  logic                            in_zero,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]   out_data,
  output logic [3:0]                      out_flags,
  output logic [3:0]                      flag_sticky,
  input  logic                            flag_clr
);

  localparam int DW = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int XW = EXP_WIDTH + 3;

  // Exponents at or above all-ones overflow; at or below zero flush.
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((2 ** EXP_WIDTH) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  localparam logic [DW-1:0] NAN_GENERIC =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
  localparam logic [DW-1:0] CANON_NAN =
    (EXP_WIDTH == BF16_EXP_W && FRAC_WIDTH == BF16_FRAC_W) ? DW'(BF16_CANON_NAN) : NAN_GENERIC;

  typedef struct packed {
    logic                  sign;
    logic                  nan;
    logic                  inf;
    logic                  zero;
    logic                  inexact;
    logic [FRAC_WIDTH-1:0] frac;
    logic [XW-1:0]         exp;
  } s1_t;

  logic adv1, adv2, out_xfer;

  logic      s1_valid_d, s1_valid_q;
  s1_t       s1_d, s1_q;
  logic      out_valid_d, out_valid_q;
  logic [DW-1:0] out_data_d, out_data_q;
  fp_flags_t out_flags_d, out_flags_q;
  logic [3:0] flag_sticky_d, flag_sticky_q;

  logic [DW-1:0] pack_data;
  fp_flags_t     pack_flags;

  logic [FRAC_WIDTH:0]        rnd_man;
  logic signed [XW-1:0]       rnd_exp;
  logic                       rnd_inexact;
  logic                       unused_hidden;

  // Stage advance: S2 frees when empty or draining, S1 when empty or S2 frees.
  assign adv2     = !out_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1;
  assign out_xfer = out_valid_q & out_ready;

  fp_rne_round #(
    .EXP_WIDTH  (EXP_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_round (
    .man     (in_man),
    .grd     (in_grd),
    .stk     (in_stk),
    .exp_in  ($signed(in_exp)),
    .man_r   (rnd_man),
    .exp_r   (rnd_exp),
    .inexact (rnd_inexact)
  );

  // The hidden bit is implied by the packed format and is not stored.
  assign unused_hidden = rnd_man[FRAC_WIDTH];

  // S1 next state: capture the rounded product whenever S1 can advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign    = in_sign;
        s1_d.nan     = in_nan;
        s1_d.inf     = in_inf;
        s1_d.zero    = in_zero;
        s1_d.inexact = rnd_inexact;
        s1_d.frac    = rnd_man[FRAC_WIDTH-1:0];
        s1_d.exp     = rnd_exp;
      end
    end
  end

  // Classify and pack with priority nan > inf > zero > overflow > underflow > normal.
  always_comb begin
    pack_data  = '0;
    pack_flags = '0;
    if (s1_q.nan) begin
      pack_data          = CANON_NAN;
      pack_flags.invalid = 1'b1;
    end else if (s1_q.inf) begin
      pack_data = {s1_q.sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    end else if (s1_q.zero) begin
      pack_data = {s1_q.sign, {(DW-1){1'b0}}};
    end else if ($signed(s1_q.exp) >= EXP_MAX) begin
      pack_data           = {s1_q.sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      pack_flags.overflow = 1'b1;
      pack_flags.inexact  = 1'b1;
    end else if ($signed(s1_q.exp) <= EXP_ZERO) begin
      pack_data            = {s1_q.sign, {(DW-1){1'b0}}};
      pack_flags.underflow = 1'b1;
      pack_flags.inexact   = 1'b1;
    end else begin
      pack_data          = {s1_q.sign, s1_q.exp[EXP_WIDTH-1:0], s1_q.frac};
      pack_flags.inexact = s1_q.inexact;
    end
  end

  // S2 next state: load a new packed result only when S2 advances with S1 full.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d  = pack_data;
        out_flags_d = pack_flags;
      end
    end
  end

  // Sticky flags: a clear coinciding with a delivery keeps that delivery's flags.
  always_comb begin
    flag_sticky_d = flag_sticky_q;
    if (flag_clr) begin
      flag_sticky_d = out_xfer ? out_flags_q : 4'b0000;
    end else if (out_xfer) begin
      flag_sticky_d = flag_sticky_q | out_flags_q;
    end
  end

  // Pipeline and flag registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_flags_q   <= '0;
      flag_sticky_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_flags_q   <= out_flags_d;
      flag_sticky_q <= flag_sticky_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_flags   = out_flags_q;
  assign flag_sticky = flag_sticky_q;

endmodule
